sram_read_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the 128-bit AXI-Lite-style read channel of the scratchpad SRAM.
- Typical masters: instruction fetch (m0) and data/accelerator load port (m1).
- One read transaction is in flight at a time: grant, forward address, return data to the granted master, release.
- Write channels do not pass through this block.

---
 rtl/sram_read_arbiter_if.sv | 31 +++
 rtl/sram_read_arbiter.sv | 116 +++++++++++
 tb/tb_sram_read_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_read_arbiter_if.sv
// Read-channel bundle (address + data handshake) shared by the masters and the SRAM.
// The master modport issues addresses and consumes data; the slave modport serves them.
interface sram_read_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0] readAddr_addr;
    logic                  readAddr_valid;
    logic                  readAddr_ready;
    logic [DATA_WIDTH-1:0] readData_data;
    logic                  readData_valid;
    logic                  readData_ready;

    modport master (
        output readAddr_addr,
        output readAddr_valid,
        input  readAddr_ready,
        input  readData_data,
        input  readData_valid,
        output readData_ready
    );

    modport slave (
        input  readAddr_addr,
        input  readAddr_valid,
        output readAddr_ready,
        output readData_data,
        output readData_valid,
        input  readData_ready
    );
endinterface

// File: rtl/sram_read_arbiter.sv
// Two-master, one-slave read arbiter for the scratchpad SRAM.
// A single transaction is in flight: grant, forward address, return data, release.
module sram_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_read_arbiter_if.slave    m0,
    sram_read_arbiter_if.slave    m1,
    sram_read_arbiter_if.master   s,
    output logic                  grant_id,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                stateReg, stateNext;
    logic                  lastGrantReg, lastGrantNext;
    logic                  grantReg, grantNext;
    logic [ADDR_WIDTH-1:0] addrReg, addrNext;

    logic [1:0]            reqValid;
    logic [ADDR_WIDTH-1:0] reqAddr [2];
    logic [1:0]            rspReady;
    logic [1:0]            addrReady;
    logic [1:0]            dataValid;
    logic [DATA_WIDTH-1:0] dataOut [2];
    logic                  winner;
    logic                  accept;
    logic                  sDataReady;

    assign reqValid   = {m1.readAddr_valid, m0.readAddr_valid};
    assign reqAddr[0] = m0.readAddr_addr;
    assign reqAddr[1] = m1.readAddr_addr;
    assign rspReady   = {m1.readData_ready, m0.readData_ready};

    // On a tie the master that did not own the last transaction wins,
    // unless fixed priority pins the tie to m0.
    always_comb begin
        if (reqValid == 2'b11) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~lastGrantReg;
        end else begin
            winner = reqValid[1];
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign addrReady[gi] = (stateReg == IDLE) && !rst && (|reqValid) && (winner == 1'(gi));
            assign dataValid[gi] = (stateReg == DATA) && (grantReg == 1'(gi)) && s.readData_valid;
            assign dataOut[gi]   = ((stateReg == DATA) && (grantReg == 1'(gi))) ? s.readData_data
                                                                                 : '0;
        end
    endgenerate

    assign accept     = |addrReady;
    assign sDataReady = (stateReg == DATA) && rspReady[grantReg];

    assign m0.readAddr_ready = addrReady[0];
    assign m1.readAddr_ready = addrReady[1];
    assign m0.readData_valid = dataValid[0];
    assign m1.readData_valid = dataValid[1];
    assign m0.readData_data  = dataOut[0];
    assign m1.readData_data  = dataOut[1];

    assign s.readAddr_valid  = (stateReg == ADDR);
    assign s.readAddr_addr   = addrReg;
    assign s.readData_ready  = sDataReady;

    assign grant_id = grantReg;
    assign busy     = (stateReg != IDLE);

    always_comb begin
        stateNext     = stateReg;
        lastGrantNext = lastGrantReg;
        grantNext     = grantReg;
        addrNext      = addrReg;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    addrNext  = reqAddr[winner];
                    grantNext = winner;
                    stateNext = ADDR;
                end
            end
            ADDR: begin
                if (s.readAddr_ready) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                // Fairness history only advances once the owner has taken its data.
                if (s.readData_valid && sDataReady) begin
                    lastGrantNext = grantReg;
                    stateNext     = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg     <= IDLE;
            lastGrantReg <= 1'b1;
            grantReg     <= 1'b0;
            addrReg      <= '0;
        end else begin
            stateReg     <= stateNext;
            lastGrantReg <= lastGrantNext;
            grantReg     <= grantNext;
            addrReg      <= addrNext;
        end
    end
endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter: round-robin instance driven from a vector table plus
// corner-case sequences, and a fixed-priority instance under continuous contention.
module tb_sram_read_arbiter;
    logic clk;
    logic rst;
    logic grantA, busyA, grantB, busyB;

    int tests = 0;
    int fails = 0;

    sram_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) m0i ();
    sram_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) m1i ();
    sram_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) si ();
    sram_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) f0i ();
    sram_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) f1i ();
    sram_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) fsi ();

    sram_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(128), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst), .m0(m0i.slave), .m1(m1i.slave), .s(si.master),
        .grant_id(grantA), .busy(busyA)
    );

    sram_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(128), .FIXED_PRIO(1)) dutFp (
        .clk(clk), .rst(rst), .m0(f0i.slave), .m1(f1i.slave), .s(fsi.master),
        .grant_id(grantB), .busy(busyB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] memData(input logic [31:0] a);
        return {32'hAABBCCDD ^ a, a, ~a, 32'h01234567 + a};
    endfunction

    // SRAM models: address always accepted, data valid the cycle after, held until taken.
    logic        pendA, pendB;
    logic [31:0] pAddrA, pAddrB;

    always @(posedge clk) begin
        if (rst) begin
            pendA <= 1'b0;
        end else if (si.readAddr_valid && si.readAddr_ready) begin
            pendA  <= 1'b1;
            pAddrA <= si.readAddr_addr;
        end else if (si.readData_valid && si.readData_ready) begin
            pendA <= 1'b0;
        end
    end
    assign si.readAddr_ready = 1'b1;
    assign si.readData_valid = pendA;
    assign si.readData_data  = pendA ? memData(pAddrA) : '0;

    always @(posedge clk) begin
        if (rst) begin
            pendB <= 1'b0;
        end else if (fsi.readAddr_valid && fsi.readAddr_ready) begin
            pendB  <= 1'b1;
            pAddrB <= fsi.readAddr_addr;
        end else if (fsi.readData_valid && fsi.readData_ready) begin
            pendB <= 1'b0;
        end
    end
    assign fsi.readAddr_ready = 1'b1;
    assign fsi.readData_valid = pendB;
    assign fsi.readData_data  = pendB ? memData(pAddrB) : '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected response queued when a request is accepted.
    typedef struct {
        bit           id;
        logic [127:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic checkRsp(input bit id, input logic [127:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL rsp_unexpected: got data on m%0d, expected none", id);
        end else begin
            e = sb.pop_front();
            chk("rsp_owner", id, e.id);
            chk("rsp_data", d, e.data);
            $display("[TB] read m%0d data=%h", id, d);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m0i.readAddr_valid && m0i.readAddr_ready)
                sb.push_back('{1'b0, memData(m0i.readAddr_addr)});
            if (m1i.readAddr_valid && m1i.readAddr_ready)
                sb.push_back('{1'b1, memData(m1i.readAddr_addr)});
            if (m0i.readData_valid && m0i.readData_ready) checkRsp(1'b0, m0i.readData_data);
            if (m1i.readData_valid && m1i.readData_ready) checkRsp(1'b1, m1i.readData_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic drive(input bit v0, input bit v1, input logic [31:0] a0, input logic [31:0] a1);
        m0i.readAddr_valid = v0;
        m0i.readAddr_addr  = a0;
        m1i.readAddr_valid = v1;
        m1i.readAddr_addr  = a1;
    endtask

    task automatic waitIdle(input string name);
        for (int k = 0; k < 12; k++) begin
            samp();
            if (!busyA) break;
            step();
        end
        chk(name, busyA, 1'b0);
    endtask

    typedef struct {
        bit          v0;
        bit          v1;
        logic [31:0] a0;
        logic [31:0] a1;
        bit          win;
    } vec_t;

    // One full transaction with exact-latency checks (slave and masters always ready).
    task automatic runVec(input vec_t v);
        logic [31:0] wa;
        wa = v.win ? v.a1 : v.a0;
        drive(v.v0, v.v1, v.a0, v.a1);
        samp();
        chk("arb_ready0", m0i.readAddr_ready, !v.win);
        chk("arb_ready1", m1i.readAddr_ready, v.win);
        chk("arb_busy_idle", busyA, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        samp();
        chk("addr_busy", busyA, 1'b1);
        chk("addr_svalid", si.readAddr_valid, 1'b1);
        chk("addr_saddr", si.readAddr_addr, wa);
        chk("addr_grant", grantA, v.win);
        step();
        samp();
        chk("data_own_valid", v.win ? m1i.readData_valid : m0i.readData_valid, 1'b1);
        chk("data_oth_valid", v.win ? m0i.readData_valid : m1i.readData_valid, 1'b0);
        chk("data_own_data", v.win ? m1i.readData_data : m0i.readData_data, memData(wa));
        chk("data_oth_data", v.win ? m0i.readData_data : m1i.readData_data, 128'h0);
        step();
        samp();
        chk("done_idle", busyA, 1'b0);
        step();
    endtask

    initial begin
        vec_t vt [8];
        bit   order [4];
        int   n;
        int   cnt0;
        int   cnt1;

        // lastGrant starts at 1, so the first tie goes to m0.
        vt[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0};
        vt[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0120, 1'b1};
        vt[2] = '{1'b1, 1'b1, 32'h0000_0030, 32'h0000_0130, 1'b0};
        vt[3] = '{1'b0, 1'b1, 32'h0,         32'hFFFF_FFF0, 1'b1};
        vt[4] = '{1'b0, 1'b1, 32'h0,         32'h0001_0000, 1'b1};
        vt[5] = '{1'b1, 1'b1, 32'h1234_5678, 32'h8765_4321, 1'b0};
        vt[6] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vt[7] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_0140, 1'b1};

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        m0i.readData_ready = 1'b1;
        m1i.readData_ready = 1'b1;
        f0i.readAddr_valid = 1'b0;
        f0i.readAddr_addr  = 32'h0000_1000;
        f1i.readAddr_valid = 1'b0;
        f1i.readAddr_addr  = 32'h0000_2000;
        f0i.readData_ready = 1'b1;
        f1i.readData_ready = 1'b1;

        repeat (2) @(posedge clk);
        samp();
        chk("rst_busy", busyA, 1'b0);
        chk("rst_grant", grantA, 1'b0);
        chk("rst_svalid", si.readAddr_valid, 1'b0);
        chk("rst_sready", si.readData_ready, 1'b0);
        chk("rst_dvalid", {m0i.readData_valid, m1i.readData_valid}, 2'b00);
        step();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) runVec(vt[i]);

        // Both masters held valid: grants must alternate m0, m1, m0, m1.
        drive(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0100);
        n = 0;
        for (int k = 0; k < 30 && n < 4; k++) begin
            samp();
            chk("rr_not_both", m0i.readAddr_ready && m1i.readAddr_ready, 1'b0);
            if (m0i.readAddr_ready) begin order[n] = 1'b0; n++; end
            else if (m1i.readAddr_ready) begin order[n] = 1'b1; n++; end
            if (n < 4) step();
        end
        chk("rr_count", n, 4);
        for (int k = 0; k < 4; k++) chk("rr_order", order[k], k % 2);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        waitIdle("rr_idle");
        step();

        // Late contender: m1 arrives while m0 owns the channel.
        drive(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        samp();
        chk("late_m0_ready", m0i.readAddr_ready, 1'b1);
        step();
        drive(1'b0, 1'b1, 32'h0, 32'h0000_0300);
        samp();
        chk("late_ready_addr", m1i.readAddr_ready, 1'b0);
        step();
        samp();
        chk("late_ready_data", m1i.readAddr_ready, 1'b0);
        chk("late_m0_dvalid", m0i.readData_valid, 1'b1);
        step();
        samp();
        chk("late_ready_idle", m1i.readAddr_ready, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        waitIdle("late_idle");
        step();

        // Back-pressure: m1 holds off its data for three cycles.
        m1i.readData_ready = 1'b0;
        drive(1'b0, 1'b1, 32'h0, 32'h0000_0440);
        samp();
        chk("bp_grant", m1i.readAddr_ready, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        samp();
        step();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) m1i.readData_ready = 1'b1;
            samp();
            chk("bp_valid", m1i.readData_valid, 1'b1);
            chk("bp_data", m1i.readData_data, memData(32'h0000_0440));
            chk("bp_sready", si.readData_ready, k == 3);
            chk("bp_busy", busyA, 1'b1);
            step();
        end
        samp();
        chk("bp_idle", busyA, 1'b0);
        step();

        // Reset while m0 waits for its data.
        m0i.readData_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0050, 32'h0);
        samp();
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        samp();
        step();
        samp();
        chk("rstd_waiting", m0i.readData_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        samp();
        chk("rstd_busy", busyA, 1'b0);
        chk("rstd_dvalid", m0i.readData_valid, 1'b0);
        chk("rstd_grant", grantA, 1'b0);
        sb.delete();
        m0i.readData_ready = 1'b1;
        step();
        drive(1'b1, 1'b1, 32'h0000_0060, 32'h0000_0160);
        samp();
        chk("rstd_tie_m0", m0i.readAddr_ready, 1'b1);
        chk("rstd_tie_m1", m1i.readAddr_ready, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        waitIdle("rstd_idle");
        step();

        // Fixed priority: m0 takes every grant, one per three cycles.
        f0i.readAddr_valid = 1'b1;
        f1i.readAddr_valid = 1'b1;
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 15; k++) begin
            samp();
            if (f0i.readAddr_ready) cnt0++;
            if (f1i.readAddr_ready) cnt1++;
            step();
        end
        f0i.readAddr_valid = 1'b0;
        f1i.readAddr_valid = 1'b0;
        chk("fp_m0_grants", cnt0, 5);
        chk("fp_m1_grants", cnt1, 0);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
